// File: rtl/ram_stream_pkg.sv
// Shared constants, FSM encoding and the read-issue room check for the RAM stream reader.
package ram_stream_pkg;

    localparam int unsigned FIFO_DEPTH       = 2;
    localparam int unsigned FIFO_COUNT_WIDTH = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCCUPANCY_WIDTH  = FIFO_COUNT_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    // A new read may issue only if the word it returns is guaranteed a FIFO slot.
    function automatic logic issue_room(
        input logic [FIFO_COUNT_WIDTH-1:0] fifo_count,
        input logic                        in_flight,
        input logic                        pop
    );
        logic [OCCUPANCY_WIDTH-1:0] occupancy;
        occupancy = OCCUPANCY_WIDTH'(fifo_count) + OCCUPANCY_WIDTH'(in_flight)
                  - OCCUPANCY_WIDTH'(pop);
        return occupancy < OCCUPANCY_WIDTH'(FIFO_DEPTH);
    endfunction

endpackage

// File: rtl/ram_stream_reader_if.sv
// Command, RAM read port and output stream bundle of the RAM stream reader.
// RAM_STREAM_CHECKSUM_EN adds the running checksum signal.
interface ram_stream_reader_if #(
    parameter int unsigned WORD_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 12
);

    logic                     start;
    logic [ADDRESS_WIDTH-1:0] start_address;
    logic [ADDRESS_WIDTH:0]   word_count;
    logic                     busy;
    logic                     done;
    logic [ADDRESS_WIDTH-1:0] ram_read_address;
    logic [WORD_WIDTH-1:0]    ram_read_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [WORD_WIDTH-1:0]    out_data;
    logic                     out_last;

`ifdef RAM_STREAM_CHECKSUM_EN
    logic [WORD_WIDTH-1:0]    checksum;

    modport master (
        input  start, start_address, word_count, ram_read_data, out_ready,
        output busy, done, ram_read_address, out_valid, out_data, out_last, checksum
    );

    modport slave (
        output start, start_address, word_count, ram_read_data, out_ready,
        input  busy, done, ram_read_address, out_valid, out_data, out_last, checksum
    );
`else
    modport master (
        input  start, start_address, word_count, ram_read_data, out_ready,
        output busy, done, ram_read_address, out_valid, out_data, out_last
    );

    modport slave (
        output start, start_address, word_count, ram_read_data, out_ready,
        input  busy, done, ram_read_address, out_valid, out_data, out_last
    );
`endif

endinterface

// File: rtl/stream_skid_fifo.sv
// Two-entry synchronous FIFO with a registered head; push and pop together keep the count.
module stream_skid_fifo
    import ram_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 33
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic                        valid,
    output logic [WIDTH-1:0]            data,
    output logic [FIFO_COUNT_WIDTH-1:0] count
);

    localparam logic [FIFO_COUNT_WIDTH-1:0] COUNT_FULL = FIFO_COUNT_WIDTH'(FIFO_DEPTH);
    localparam logic [FIFO_COUNT_WIDTH-1:0] COUNT_ONE  = FIFO_COUNT_WIDTH'(1);

    logic [WIDTH-1:0]            head_q;
    logic [WIDTH-1:0]            tail_q;
    logic [FIFO_COUNT_WIDTH-1:0] count_q;
    logic                        pop_ok;
    logic                        push_ok;

    assign pop_ok  = pop & (count_q != '0);
    assign push_ok = push & ((count_q != COUNT_FULL) | pop_ok);

    // Head always holds the oldest entry so the output needs no read mux.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count_q == '0) begin
                        head_q <= push_data;
                    end else begin
                        tail_q <= push_data;
                    end
                    count_q <= count_q + COUNT_ONE;
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - COUNT_ONE;
                end
                2'b11: begin
                    if (count_q == COUNT_ONE) begin
                        head_q <= push_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign valid = (count_q != '0);
    assign data  = head_q;
    assign count = count_q;

endmodule

// File: rtl/ram_stream_reader.sv
// DMA-style read engine: streams a block of RAM words out over valid/ready with a 1-cycle RAM latency.
// Define RAM_STREAM_CHECKSUM_EN to add the running checksum of accepted beats.
module ram_stream_reader
    import ram_stream_pkg::*;
#(
    parameter int unsigned WORD_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 12
) (
    input logic              clock,
    input logic              reset,
    ram_stream_reader_if.master bus
);

    localparam int unsigned COUNT_WIDTH = ADDRESS_WIDTH + 1;
    localparam int unsigned ENTRY_WIDTH = WORD_WIDTH + 1;

    state_e                      state_q;
    state_e                      state_d;
    logic [ADDRESS_WIDTH-1:0]    address_q;
    logic [COUNT_WIDTH-1:0]      remaining_q;
    logic                        in_flight_q;
    logic                        in_flight_last_q;
    logic                        busy_q;
    logic                        done_q;
    logic                        busy_d;
    logic                        done_d;
    logic                        load_c;
    logic                        issue_c;
    logic                        pop_c;
    logic                        last_beat_c;
    logic                        fifo_valid;
    logic [ENTRY_WIDTH-1:0]      fifo_data;
    logic [FIFO_COUNT_WIDTH-1:0] fifo_count;

    assign pop_c       = fifo_valid & bus.out_ready;
    assign last_beat_c = pop_c & fifo_data[WORD_WIDTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        issue_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    load_c  = 1'b1;
                    state_d = (bus.word_count == '0) ? ST_FINISH : ST_RUN;
                end
            end
            ST_RUN: begin
                issue_c = (remaining_q != '0) && issue_room(fifo_count, in_flight_q, pop_c);
                if (last_beat_c) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_FINISH);
    end

    // Address/issue bookkeeping; the last-issued flag travels with its word into the FIFO.
    always_ff @(posedge clock) begin
        if (reset) begin
            address_q        <= '0;
            remaining_q      <= '0;
            in_flight_q      <= 1'b0;
            in_flight_last_q <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            busy_q           <= busy_d;
            done_q           <= done_d;
            in_flight_q      <= issue_c;
            in_flight_last_q <= issue_c && (remaining_q == COUNT_WIDTH'(1));
            if (load_c) begin
                address_q   <= bus.start_address;
                remaining_q <= bus.word_count;
            end else if (issue_c) begin
                address_q   <= address_q + ADDRESS_WIDTH'(1);
                remaining_q <= remaining_q - COUNT_WIDTH'(1);
            end
        end
    end

    stream_skid_fifo #(
        .WIDTH (ENTRY_WIDTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (in_flight_q),
        .push_data ({in_flight_last_q, bus.ram_read_data}),
        .pop       (pop_c),
        .valid     (fifo_valid),
        .data      (fifo_data),
        .count     (fifo_count)
    );

    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.ram_read_address = address_q;
    assign bus.out_valid        = fifo_valid;
    assign bus.out_data         = fifo_data[WORD_WIDTH-1:0];
    assign bus.out_last         = fifo_valid & fifo_data[WORD_WIDTH];

`ifdef RAM_STREAM_CHECKSUM_EN
    logic [WORD_WIDTH-1:0] checksum_q;

    // Sum of accepted beats; cleared by an accepted start so it holds from done to next start.
    always_ff @(posedge clock) begin
        if (reset) begin
            checksum_q <= '0;
        end else if (load_c) begin
            checksum_q <= '0;
        end else if (pop_c) begin
            checksum_q <= checksum_q + fifo_data[WORD_WIDTH-1:0];
        end
    end

    assign bus.checksum = checksum_q;
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader: RAM model with 1-cycle latency and a word-sequence reference.
module tb_ram_stream_reader;

    logic clock;
    logic reset;

    ram_stream_reader_if #(.WORD_WIDTH(32), .ADDRESS_WIDTH(12)) bus ();

    ram_stream_reader #(.WORD_WIDTH(32), .ADDRESS_WIDTH(12)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [0:4095];

    always @(posedge clock) bus.ram_read_data <= mem[bus.ram_read_address];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_compared;
    int n_mismatched;

    logic [31:0] got_data [$];
    bit          got_last [$];
    int          first_valid;
    int          done_cycle;
    int          last_beat_cycle;
    int          done_count;
    int          busy_cycles;
    int          stall_changes;
    int          post_activity;
    bit          timed_out;
    logic [31:0] checksum_at_done;

    // Reference: the k-th beat of a transfer is the RAM word at (start + k) mod depth.
    function automatic logic [31:0] model_word(input logic [11:0] addr, input int i);
        int a;
        a = (int'(addr) + i) % 4096;
        return mem[a];
    endfunction

    function automatic bit ready_for(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (k % 3) == 0;
        return $urandom_range(0, 3) != 0;
    endfunction

    // Drives one start command and records what the DUT streams until done plus three idle cycles.
    task automatic run_transfer(input logic [11:0] addr, input logic [12:0] count,
                                input int ready_mode, input int inject_cycle,
                                input bit inject_at_done, input int budget);
        int          k;
        int          tail;
        bit          prev_stall;
        bit          seen_done;
        logic [31:0] prev_data;
        got_data.delete();
        got_last.delete();
        first_valid      = -1;
        done_cycle       = -1;
        last_beat_cycle  = -1;
        done_count       = 0;
        busy_cycles      = 0;
        stall_changes    = 0;
        post_activity    = 0;
        timed_out        = 1'b0;
        checksum_at_done = '0;
        prev_stall       = 1'b0;
        prev_data        = '0;
        seen_done        = 1'b0;
        tail             = 0;
        k                = 0;
        @(negedge clock);
        bus.start         = 1'b1;
        bus.start_address = addr;
        bus.word_count    = count;
        bus.out_ready     = 1'b1;
        forever begin
            @(negedge clock);
            bus.start = 1'b0;
            if (k == inject_cycle) begin
                bus.start         = 1'b1;
                bus.start_address = 12'h555;
                bus.word_count    = 13'd3;
            end
            bus.out_ready = ready_for(ready_mode, k);
            if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_data !== prev_data))
                stall_changes++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            if (bus.done) done_count++;
            if (seen_done) begin
                if (bus.out_valid || bus.busy) post_activity++;
                tail++;
                if (tail == 3) break;
            end else begin
                if (bus.busy) busy_cycles++;
                if (bus.out_valid && first_valid < 0) first_valid = k;
                if (bus.out_valid && bus.out_ready) begin
                    got_data.push_back(bus.out_data);
                    got_last.push_back(bus.out_last);
                    last_beat_cycle = k;
                end
                if (bus.done) begin
                    done_cycle = k;
                    seen_done  = 1'b1;
`ifdef RAM_STREAM_CHECKSUM_EN
                    checksum_at_done = bus.checksum;
`endif
                    if (inject_at_done) begin
                        bus.start         = 1'b1;
                        bus.start_address = 12'h2AA;
                        bus.word_count    = 13'd2;
                    end
                end
            end
            k++;
            if (k > budget) begin
                timed_out = 1'b1;
                break;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_compared++; if (bus.busy !== 1'b0) begin n_mismatched++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_compared++; if (bus.done !== 1'b0) begin n_mismatched++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_compared++; if (bus.out_valid !== 1'b0) begin n_mismatched++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        n_compared++; if (bus.out_last !== 1'b0) begin n_mismatched++; $display("FAIL reset_last: got %b want 0", bus.out_last); end
        n_compared++; if (bus.ram_read_address !== 12'h000) begin n_mismatched++; $display("FAIL reset_addr: got %h want 000", bus.ram_read_address); end
        n_compared++; if (bus.out_data !== 32'h0) begin n_mismatched++; $display("FAIL reset_data: got %h want 0", bus.out_data); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic;
        run_transfer(12'h010, 13'd4, 0, -1, 1'b0, 60);
        n_compared++; if (timed_out !== 1'b0) begin n_mismatched++; $display("FAIL basic_timeout: got %b want 0", timed_out); end
        n_compared++; if (got_data.size() !== 4) begin n_mismatched++; $display("FAIL basic_len: got %0d want 4", got_data.size()); end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            n_compared++; if (got_data[i] !== 32'hA5A5_0010 + 32'(i)) begin n_mismatched++; $display("FAIL basic_data[%0d]: got %h want %h", i, got_data[i], 32'hA5A5_0010 + 32'(i)); end
            n_compared++; if (got_last[i] !== (i == 3)) begin n_mismatched++; $display("FAIL basic_last[%0d]: got %b want %b", i, got_last[i], i == 3); end
        end
        n_compared++; if (first_valid !== 2) begin n_mismatched++; $display("FAIL basic_latency: got %0d want 2", first_valid); end
        n_compared++; if (last_beat_cycle !== 5) begin n_mismatched++; $display("FAIL basic_last_cycle: got %0d want 5", last_beat_cycle); end
        n_compared++; if (done_cycle !== 6) begin n_mismatched++; $display("FAIL basic_done_cycle: got %0d want 6", done_cycle); end
        n_compared++; if (busy_cycles !== 6) begin n_mismatched++; $display("FAIL basic_busy_cycles: got %0d want 6", busy_cycles); end
        n_compared++; if (done_count !== 1) begin n_mismatched++; $display("FAIL basic_done_count: got %0d want 1", done_count); end
        n_compared++; if (post_activity !== 0) begin n_mismatched++; $display("FAIL basic_post: got %0d want 0", post_activity); end
    endtask

    task automatic test_backpressure;
        run_transfer(12'h010, 13'd4, 1, -1, 1'b0, 80);
        n_compared++; if (timed_out !== 1'b0) begin n_mismatched++; $display("FAIL bp_timeout: got %b want 0", timed_out); end
        n_compared++; if (got_data.size() !== 4) begin n_mismatched++; $display("FAIL bp_len: got %0d want 4", got_data.size()); end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            n_compared++; if (got_data[i] !== model_word(12'h010, i)) begin n_mismatched++; $display("FAIL bp_data[%0d]: got %h want %h", i, got_data[i], model_word(12'h010, i)); end
            n_compared++; if (got_last[i] !== (i == 3)) begin n_mismatched++; $display("FAIL bp_last[%0d]: got %b want %b", i, got_last[i], i == 3); end
        end
        n_compared++; if (stall_changes !== 0) begin n_mismatched++; $display("FAIL bp_hold: got %0d changes want 0", stall_changes); end
        n_compared++; if (done_cycle !== last_beat_cycle + 1) begin n_mismatched++; $display("FAIL bp_done_cycle: got %0d want %0d", done_cycle, last_beat_cycle + 1); end
        n_compared++; if (done_count !== 1) begin n_mismatched++; $display("FAIL bp_done_count: got %0d want 1", done_count); end
    endtask

    task automatic test_wrap;
        run_transfer(12'hFFE, 13'd4, 2, -1, 1'b0, 80);
        n_compared++; if (got_data.size() !== 4) begin n_mismatched++; $display("FAIL wrap_len: got %0d want 4", got_data.size()); end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            n_compared++; if (got_data[i] !== model_word(12'hFFE, i)) begin n_mismatched++; $display("FAIL wrap_data[%0d]: got %h want %h", i, got_data[i], model_word(12'hFFE, i)); end
            n_compared++; if (got_last[i] !== (i == 3)) begin n_mismatched++; $display("FAIL wrap_last[%0d]: got %b want %b", i, got_last[i], i == 3); end
        end
        n_compared++; if (stall_changes !== 0) begin n_mismatched++; $display("FAIL wrap_hold: got %0d want 0", stall_changes); end
        n_compared++; if (done_count !== 1) begin n_mismatched++; $display("FAIL wrap_done_count: got %0d want 1", done_count); end
    endtask

    task automatic test_zero_count;
        run_transfer(12'(($urandom_range(0, 4095))), 13'd0, 0, -1, 1'b1, 20);
        n_compared++; if (got_data.size() !== 0) begin n_mismatched++; $display("FAIL zero_beats: got %0d want 0", got_data.size()); end
        n_compared++; if (first_valid !== -1) begin n_mismatched++; $display("FAIL zero_valid: got cycle %0d want none", first_valid); end
        n_compared++; if (busy_cycles !== 0) begin n_mismatched++; $display("FAIL zero_busy: got %0d want 0", busy_cycles); end
        n_compared++; if (done_cycle !== 0) begin n_mismatched++; $display("FAIL zero_done_cycle: got %0d want 0", done_cycle); end
        n_compared++; if (done_count !== 1) begin n_mismatched++; $display("FAIL zero_done_count: got %0d want 1", done_count); end
        n_compared++; if (post_activity !== 0) begin n_mismatched++; $display("FAIL zero_post: got %0d want 0", post_activity); end
    endtask

    task automatic test_start_ignored;
        run_transfer(12'h123, 13'd5, 0, 2, 1'b1, 60);
        n_compared++; if (got_data.size() !== 5) begin n_mismatched++; $display("FAIL ignore_len: got %0d want 5", got_data.size()); end
        for (int i = 0; i < 5 && i < got_data.size(); i++) begin
            n_compared++; if (got_data[i] !== model_word(12'h123, i)) begin n_mismatched++; $display("FAIL ignore_data[%0d]: got %h want %h", i, got_data[i], model_word(12'h123, i)); end
        end
        n_compared++; if (busy_cycles !== 7) begin n_mismatched++; $display("FAIL ignore_busy_cycles: got %0d want 7", busy_cycles); end
        n_compared++; if (done_count !== 1) begin n_mismatched++; $display("FAIL ignore_done_count: got %0d want 1", done_count); end
        n_compared++; if (post_activity !== 0) begin n_mismatched++; $display("FAIL ignore_post: got %0d want 0", post_activity); end
    endtask

    task automatic test_reset_abort;
        int beats;
        int k;
        int stray;
        beats = 0;
        k     = 0;
        stray = 0;
        @(negedge clock);
        bus.start         = 1'b1;
        bus.start_address = 12'h200;
        bus.word_count    = 13'd8;
        bus.out_ready     = 1'b1;
        while (beats < 3 && k < 40) begin
            @(negedge clock);
            bus.start = 1'b0;
            if (bus.out_valid && bus.out_ready) beats++;
            k++;
        end
        n_compared++; if (beats !== 3) begin n_mismatched++; $display("FAIL abort_beats: got %0d want 3", beats); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_compared++; if (bus.out_valid !== 1'b0) begin n_mismatched++; $display("FAIL abort_valid: got %b want 0", bus.out_valid); end
        n_compared++; if (bus.busy !== 1'b0) begin n_mismatched++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        n_compared++; if (bus.done !== 1'b0) begin n_mismatched++; $display("FAIL abort_done: got %b want 0", bus.done); end
        repeat (5) begin
            @(negedge clock);
            if (bus.out_valid || bus.busy || bus.done) stray++;
        end
        n_compared++; if (stray !== 0) begin n_mismatched++; $display("FAIL abort_quiet: got %0d active cycles want 0", stray); end
        run_transfer(12'h040, 13'd6, 0, -1, 1'b0, 60);
        n_compared++; if (got_data.size() !== 6) begin n_mismatched++; $display("FAIL abort_fresh_len: got %0d want 6", got_data.size()); end
        for (int i = 0; i < 6 && i < got_data.size(); i++) begin
            n_compared++; if (got_data[i] !== model_word(12'h040, i)) begin n_mismatched++; $display("FAIL abort_fresh_data[%0d]: got %h want %h", i, got_data[i], model_word(12'h040, i)); end
        end
        n_compared++; if (done_cycle !== 8) begin n_mismatched++; $display("FAIL abort_fresh_done: got %0d want 8", done_cycle); end
    endtask

`ifdef RAM_STREAM_CHECKSUM_EN
    task automatic test_checksum;
        logic [31:0] sum;
        sum = '0;
        for (int i = 0; i < 4; i++) sum = sum + model_word(12'h010, i);
        run_transfer(12'h010, 13'd4, 1, -1, 1'b0, 80);
        n_compared++; if (checksum_at_done !== sum) begin n_mismatched++; $display("FAIL checksum: got %h want %h", checksum_at_done, sum); end
        n_compared++; if (bus.checksum !== sum) begin n_mismatched++; $display("FAIL checksum_hold: got %h want %h", bus.checksum, sum); end
    endtask
`endif

    task automatic test_random_transfers;
        logic [11:0] addr;
        int          cnt;
        int          mode;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        for (int t = 0; t < 6; t++) begin
            addr = 12'($urandom_range(0, 4095));
            cnt  = $urandom_range(1, 24);
            mode = $urandom_range(0, 2);
            run_transfer(addr, 13'(cnt), mode, -1, 1'b0, cnt * 8 + 40);
            n_compared++; if (got_data.size() !== cnt) begin n_mismatched++; $display("FAIL rand%0d_len: got %0d want %0d", t, got_data.size(), cnt); end
            for (int i = 0; i < cnt && i < got_data.size(); i++) begin
                n_compared++; if (got_data[i] !== model_word(addr, i)) begin n_mismatched++; $display("FAIL rand%0d_data[%0d]: got %h want %h", t, i, got_data[i], model_word(addr, i)); end
                n_compared++; if (got_last[i] !== (i == cnt - 1)) begin n_mismatched++; $display("FAIL rand%0d_last[%0d]: got %b want %b", t, i, got_last[i], i == cnt - 1); end
            end
            n_compared++; if (stall_changes !== 0) begin n_mismatched++; $display("FAIL rand%0d_hold: got %0d want 0", t, stall_changes); end
            n_compared++; if (done_count !== 1) begin n_mismatched++; $display("FAIL rand%0d_done_count: got %0d want 1", t, done_count); end
            if (mode == 0) begin
                n_compared++; if (done_cycle !== cnt + 2) begin n_mismatched++; $display("FAIL rand%0d_done_cycle: got %0d want %0d", t, done_cycle, cnt + 2); end
            end
        end
    endtask

    task automatic test_full_transfer;
        logic [11:0] addr;
        int          bad;
        addr = 12'($urandom_range(0, 4095));
        bad  = 0;
        run_transfer(addr, 13'h1000, 0, -1, 1'b0, 4200);
        n_compared++; if (got_data.size() !== 4096) begin n_mismatched++; $display("FAIL full_len: got %0d want 4096", got_data.size()); end
        for (int i = 0; i < 4096 && i < got_data.size(); i++) begin
            if (got_data[i] !== model_word(addr, i) || got_last[i] !== (i == 4095)) bad++;
        end
        n_compared++; if (bad !== 0) begin n_mismatched++; $display("FAIL full_words: got %0d bad beats want 0", bad); end
        n_compared++; if (done_cycle !== 4098) begin n_mismatched++; $display("FAIL full_done_cycle: got %0d want 4098", done_cycle); end
    endtask

    initial begin
        n_compared        = 0;
        n_mismatched      = 0;
        reset             = 1'b1;
        bus.start         = 1'b0;
        bus.start_address = '0;
        bus.word_count    = '0;
        bus.out_ready     = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'(i) ^ 32'hA5A5_0000;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_count();
        test_start_ignored();
        test_reset_abort();
`ifdef RAM_STREAM_CHECKSUM_EN
        test_checksum();
`endif
        test_random_transfers();
        test_full_transfer();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
